ysyx_23060236_trap_sequencer: RTL

- Sequences all trap-related CSR traffic for the core: synchronous exceptions, ecall, mret and the machine timer interrupt.
- Sits between WBU commit and the CSR file, which has a single write port and one combinational read port.
- Arbitrates that port between ordinary CSR instructions and multi-cycle trap entry/exit sequences.
- Produces a one-cycle PC redirect to IFU once a sequence completes.

---
 rtl/ysyx_23060236_trap_sequencer_pkg.sv | 32 +++
 rtl/ysyx_23060236_trap_sequencer_mstatus_xform.sv | 26 ++
 rtl/ysyx_23060236_trap_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060236_trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions and the sequencer state encoding.
package ysyx_23060236_trap_sequencer_pkg;

    // CSR addresses touched by trap entry/exit
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Exception / interrupt codes
    localparam int CAUSE_ILLEGAL = 2;
    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_MTIMER  = 7;

    // mstatus fields
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EPC    = 3'd1,
        ST_CAUSE  = 3'd2,
        ST_STATUS = 3'd3,
        ST_MSTAT  = 3'd4,
        ST_JUMP   = 3'd5
    } state_e;

endpackage

// File: rtl/ysyx_23060236_trap_sequencer_mstatus_xform.sv
// Combinational mstatus rewrite for trap entry (is_mret_i = 0) and
// mret (is_mret_i = 1). MPP is forced to machine mode in both cases.
module ysyx_23060236_mstatus_xform
    import ysyx_23060236_trap_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic            is_mret_i,
    output logic [XLEN-1:0] mstatus_o
);

    // Move the interrupt-enable stack one way or the other
    always_comb begin
        mstatus_o = rdata_i;
        if (is_mret_i) begin
            mstatus_o[MSTATUS_MIE]  = rdata_i[MSTATUS_MPIE];
            mstatus_o[MSTATUS_MPIE] = 1'b1;
        end else begin
            mstatus_o[MSTATUS_MPIE] = rdata_i[MSTATUS_MIE];
            mstatus_o[MSTATUS_MIE]  = 1'b0;
        end
        mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/ysyx_23060236_trap_sequencer.sv
// Trap sequencer: arbitrates the single CSR write port between ordinary
// CSR-instruction writes and multi-cycle trap entry / mret sequences, and
// issues a one-cycle PC redirect when a sequence finishes.
// Optional: define YSYX_23060236_TRAP_VECTORED_EN to honour vectored
// mtvec mode for interrupts.
module ysyx_23060236_trap_sequencer
    import ysyx_23060236_trap_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 6
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [XLEN-1:0]    req_pc_i,
    input  logic               req_exc_i,
    input  logic [CAUSE_W-1:0] req_cause_i,
    input  logic               req_mret_i,
    input  logic               req_csr_wen_i,
    input  logic [11:0]        req_csr_addr_i,
    input  logic [XLEN-1:0]    req_csr_wdata_i,
    input  logic               irq_timer_i,
    output logic [11:0]        csr_raddr_o,
    input  logic [XLEN-1:0]    csr_rdata_i,
    output logic               csr_wen_o,
    output logic [11:0]        csr_waddr_o,
    output logic [XLEN-1:0]    csr_wdata_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               busy_o
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [CAUSE_W:0]   cause_q, cause_d;      // MSB = interrupt flag
    logic               jump_mret_q, jump_mret_d;

    logic               handshake;
    logic               irq_take;
    logic [XLEN-1:0]    mstatus_new;
    logic [XLEN-1:0]    jump_target;

    // In IDLE csr_raddr points at mstatus, so rdata carries the live MIE bit
    assign handshake = req_valid_i && (state_q == ST_IDLE);
    assign irq_take  = irq_timer_i && csr_rdata_i[MSTATUS_MIE];

    ysyx_23060236_mstatus_xform #(
        .XLEN (XLEN)
    ) u_mstatus_xform (
        .rdata_i   (csr_rdata_i),
        .is_mret_i (state_q == ST_MSTAT),
        .mstatus_o (mstatus_new)
    );

    // State and latched trap context; reset abandons any sequence in flight
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            epc_q       <= '0;
            cause_q     <= '0;
            jump_mret_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            jump_mret_q <= jump_mret_d;
        end
    end

    // Next-state selection: exception > mret > timer irq > plain commit
    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        jump_mret_d = jump_mret_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (req_exc_i) begin
                        epc_d       = req_pc_i;
                        cause_d     = {1'b0, req_cause_i};
                        jump_mret_d = 1'b0;
                        state_d     = ST_EPC;
                    end else if (req_mret_i) begin
                        jump_mret_d = 1'b1;
                        state_d     = ST_MSTAT;
                    end else if (irq_take) begin
                        epc_d       = req_pc_i;
                        cause_d     = {1'b1, CAUSE_W'(CAUSE_MTIMER)};
                        jump_mret_d = 1'b0;
                        state_d     = ST_EPC;
                    end
                end
            end
            ST_EPC:    state_d = ST_CAUSE;
            ST_CAUSE:  state_d = ST_STATUS;
            ST_STATUS: state_d = ST_JUMP;
            ST_MSTAT:  state_d = ST_JUMP;
            ST_JUMP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Redirect target: mtvec base (optionally vectored for interrupts) or mepc
    always_comb begin
        jump_target = {csr_rdata_i[XLEN-1:2], 2'b00};
`ifdef YSYX_23060236_TRAP_VECTORED_EN
        if (!jump_mret_q && cause_q[CAUSE_W] && (csr_rdata_i[1:0] == 2'b01)) begin
            jump_target = {csr_rdata_i[XLEN-1:2], 2'b00}
                        + (XLEN'(cause_q[CAUSE_W-1:0]) << 2);
        end
`endif
    end

    // Per-state CSR port, handshake and redirect outputs; all quiet in reset
    always_comb begin
        req_ready_o      = 1'b0;
        csr_raddr_o      = '0;
        csr_wen_o        = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = 1'b0;
        if (reset_ni) begin
            busy_o = (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_o = 1'b1;
                    csr_raddr_o = CSR_MSTATUS;
                    if (req_valid_i && !req_exc_i && !req_mret_i && !irq_take
                        && req_csr_wen_i) begin
                        csr_wen_o   = 1'b1;
                        csr_waddr_o = req_csr_addr_i;
                        csr_wdata_o = req_csr_wdata_i;
                    end
                end
                ST_EPC: begin
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = epc_q;
                end
                ST_CAUSE: begin
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = {cause_q[CAUSE_W], {(XLEN-CAUSE_W-1){1'b0}},
                                   cause_q[CAUSE_W-1:0]};
                end
                ST_STATUS, ST_MSTAT: begin
                    csr_raddr_o = CSR_MSTATUS;
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mstatus_new;
                end
                ST_JUMP: begin
                    csr_raddr_o      = jump_mret_q ? CSR_MEPC : CSR_MTVEC;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = jump_target;
                end
                default: ;
            endcase
        end
    end

endmodule
